// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM external bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  // Arbiter FSM states; DONE is the one-cycle ack/turnaround state.
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2,
    ARB_DONE     = 2'd3
  } arb_state_t;

  localparam logic        RstEnable           = 1'b1;
  localparam logic [31:0] ZeroWord            = 32'h0000_0000;
  localparam int          DEFAULT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Bus watchdog: counts cycles while enabled, flags the LIMIT-th enabled cycle.
// Latency: expired is combinational from the count; the count updates each edge.
// Backpressure: none; clr wins over en, the count saturates at LIMIT-1.
//
// Ports: clk, rst (sync, active high), clr (restart count), en (count this
//        cycle), expired (this is the LIMIT-th consecutive enabled cycle).
module arb_timeout_cnt
  import bus_arbiter_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The count holds the number of enabled cycles already elapsed, so the
  // cycle that sees LAST is the LIMIT-th one.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM stage.
// Latency: request seen in IDLE -> bus_cyc next cycle -> ack the cycle after
//          bus_ack (2 cycles minimum), then one turnaround cycle before the next grant.
// Backpressure: requesters hold req until ack; stallreq_* hold the pipeline meanwhile.
//
// Ports: clk, rst (sync, active high); if_req/if_addr -> if_rdata/if_ack;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_sel -> mem_rdata/mem_ack;
//        bus_cyc/bus_we/bus_addr/bus_wdata/bus_sel out, bus_rdata/bus_ack in;
//        bus_err (watchdog pulse); stallreq_from_if, stallreq_from_mem.
// Build option: define BUS_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYC
//        cycles without bus_ack; otherwise the arbiter waits forever.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                bus_cyc,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                bus_err,
  output logic                stallreq_from_if,
  output logic                stallreq_from_mem
);

  localparam logic [DATA_W-1:0] ZERO_DAT = DATA_W'(ZeroWord);

  arb_state_t state;
  logic       if_ack_r;
  logic       mem_ack_r;
  logic       bus_err_r;
  logic       timeout_hit;

`ifdef BUS_TIMEOUT_EN
  // Cleared while idle, so every grant starts from zero.
  arb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ARB_IDLE),
    .en      (bus_cyc),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state     <= ARB_IDLE;
      bus_cyc   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= ZERO_DAT;
      bus_sel   <= '0;
      if_rdata  <= ZERO_DAT;
      mem_rdata <= ZERO_DAT;
      if_ack_r  <= 1'b0;
      mem_ack_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      if_ack_r  <= 1'b0;
      mem_ack_r <= 1'b0;
      bus_err_r <= 1'b0;
      case (state)
        ARB_IDLE: begin
          // MEM holds the older instruction; serving it first keeps the
          // stall controller from waiting on a younger fetch.
          if (mem_req) begin
            state     <= ARB_MEM_BUSY;
            bus_cyc   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_sel   <= mem_sel;
          end else if (if_req) begin
            state     <= ARB_IF_BUSY;
            bus_cyc   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= ZERO_DAT;
            bus_sel   <= '1;
          end
        end
        ARB_IF_BUSY: begin
          if (bus_ack) begin
            state    <= ARB_DONE;
            bus_cyc  <= 1'b0;
            if_rdata <= bus_rdata;
            if_ack_r <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ARB_DONE;
            bus_cyc   <= 1'b0;
            if_rdata  <= ZERO_DAT;
            if_ack_r  <= 1'b1;
            bus_err_r <= 1'b1;
          end
        end
        ARB_MEM_BUSY: begin
          if (bus_ack) begin
            state     <= ARB_DONE;
            bus_cyc   <= 1'b0;
            mem_rdata <= bus_we ? ZERO_DAT : bus_rdata;
            mem_ack_r <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ARB_DONE;
            bus_cyc   <= 1'b0;
            mem_rdata <= ZERO_DAT;
            mem_ack_r <= 1'b1;
            bus_err_r <= 1'b1;
          end
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // A requester flushed mid-transaction has dropped req by DONE, so the
  // live req masks the stale completion.
  assign if_ack  = if_ack_r & if_req;
  assign mem_ack = mem_ack_r & mem_req;
  assign bus_err = bus_err_r;

  assign stallreq_from_if  = if_req & ~if_ack;
  assign stallreq_from_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed cases with hand-computed values plus a
// randomized run checked every cycle against a transaction-level model.
module tb_bus_arbiter;

  localparam int TO_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_rdata          (if_rdata),
    .if_ack            (if_ack),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_sel           (mem_sel),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .bus_cyc           (bus_cyc),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_sel           (bus_sel),
    .bus_rdata         (bus_rdata),
    .bus_ack           (bus_ack),
    .bus_err           (bus_err),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Who owns the bus, when it was granted, and the first cycle a new
  // request may be accepted; outputs follow from those timestamps.
  int          m_cyc_n  = 0;
  int          m_owner  = 0;   // 0 none, 1 IF, 2 MEM
  int          m_start  = 0;
  int          m_free_at = 0;
  bit          m_fin;
  logic [31:0] m_rd;
  logic        m_cyc = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_if_rdata = '0, m_mem_rdata = '0;
  logic        m_if_done = 1'b0, m_mem_done = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_free_at = 0;
      m_cyc = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_sel = '0;
      m_if_rdata = '0; m_mem_rdata = '0;
      m_if_done = 0; m_mem_done = 0; m_err = 0;
    end else begin
      m_if_done = 0; m_mem_done = 0; m_err = 0;
      if (m_owner != 0) begin
        m_fin = 0;
        m_rd  = '0;
        if (bus_ack) begin
          m_fin = 1;
          m_rd  = (m_owner == 2 && m_we) ? 32'h0 : bus_rdata;
        end
`ifdef BUS_TIMEOUT_EN
        else if (m_cyc_n - m_start == TO_CYC) begin
          m_fin = 1;
          m_err = 1;
        end
`endif
        if (m_fin) begin
          if (m_owner == 1) begin m_if_rdata = m_rd; m_if_done = 1; end
          else begin m_mem_rdata = m_rd; m_mem_done = 1; end
          m_cyc     = 0;
          m_owner   = 0;
          m_free_at = m_cyc_n + 2;
        end
      end else if (m_cyc_n >= m_free_at) begin
        if (mem_req) begin
          m_owner = 2; m_start = m_cyc_n; m_cyc = 1;
          m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_sel = mem_sel;
        end else if (if_req) begin
          m_owner = 1; m_start = m_cyc_n; m_cyc = 1;
          m_we = 0; m_addr = if_addr; m_sel = 4'hF;
        end
      end
    end
    m_cyc_n++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("bus_cyc", bus_cyc, m_cyc);
      if (m_cyc) begin
        chk("bus_we", bus_we, m_we);
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_sel", bus_sel, m_sel);
        if (m_we) chk("bus_wdata", bus_wdata, m_wdata);
      end
      chk("if_ack", if_ack, m_if_done & if_req);
      chk("mem_ack", mem_ack, m_mem_done & mem_req);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      chk("bus_err", bus_err, m_err);
      chk("stall_if", stallreq_from_if, if_req & ~(m_if_done & if_req));
      chk("stall_mem", stallreq_from_mem, mem_req & ~(m_mem_done & mem_req));
    end
  end

  // ---------------- stimulus ----------------
  int slave_mode = 0;  // 0 manual, 1 fixed wait states, 2 random
  int waits = 0;
  int seen = 0;

  task automatic step();
    @(negedge clk);
    if (slave_mode == 1) begin
      if (bus_cyc) seen++; else seen = 0;
      bus_ack = bus_cyc && (seen > waits);
    end else if (slave_mode == 2) begin
      bus_ack   = bus_cyc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus_rdata = $urandom;
    end
  endtask

  bit if_got = 0, mem_got = 0;
  int if_cool = 0, mem_cool = 0;

  initial begin
    rst = 1; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0;
    mem_addr = '0; mem_wdata = '0; mem_sel = '0; bus_rdata = '0; bus_ack = 0;

    step();
    step(); chk_en = 1; #2;
    chk("rst_bus_cyc", bus_cyc, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    chk("rst_bus_err", bus_err, 0);
    step(); rst = 0;

    // 1: single fetch, zero-wait slave
    step(); if_req = 1; if_addr = 32'h100; #2;
    chk("t1_c0_stall_if", stallreq_from_if, 1);
    chk("t1_c0_cyc", bus_cyc, 0);
    step(); bus_ack = 1; bus_rdata = 32'hDEADBEEF; #2;
    chk("t1_c1_cyc", bus_cyc, 1);
    chk("t1_c1_addr", bus_addr, 32'h100);
    chk("t1_c1_sel", bus_sel, 4'hF);
    chk("t1_c1_stall_if", stallreq_from_if, 1);
    step(); bus_ack = 0; #2;
    chk("t1_c2_if_ack", if_ack, 1);
    chk("t1_c2_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_c2_stall_if", stallreq_from_if, 0);
    step(); if_req = 0; #2;
    chk("t1_c3_if_ack", if_ack, 0);

    // 2: simultaneous requests, MEM write wins
    slave_mode = 1; waits = 0; bus_rdata = 32'hCAFEF00D;
    step(); mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'h12345678;
    mem_sel = 4'hF; if_req = 1; if_addr = 32'h300;
    step(); #2;
    chk("t2_c1_we", bus_we, 1);
    chk("t2_c1_addr", bus_addr, 32'h200);
    chk("t2_c1_wdata", bus_wdata, 32'h12345678);
    step(); #2;
    chk("t2_c2_mem_ack", mem_ack, 1);
    chk("t2_c2_mem_rdata", mem_rdata, 0);
    chk("t2_c2_stall_if", stallreq_from_if, 1);
    step(); mem_req = 0; #2;
    chk("t2_c3_cyc", bus_cyc, 0);
    step(); #2;
    chk("t2_c4_cyc", bus_cyc, 1);
    chk("t2_c4_addr", bus_addr, 32'h300);
    step(); #2;
    chk("t2_c5_if_ack", if_ack, 1);
    chk("t2_c5_if_rdata", if_rdata, 32'hCAFEF00D);
    step(); if_req = 0;

    // 3: MEM read, three wait states
    waits = 3; bus_rdata = 32'hA5A55A5A;
    step(); mem_req = 1; mem_we = 0; mem_addr = 32'h404; mem_sel = 4'h3;
    for (int c = 1; c <= 4; c++) begin
      step(); #2;
      chk("t3_wait_cyc", bus_cyc, 1);
      chk("t3_wait_addr", bus_addr, 32'h404);
      chk("t3_wait_sel", bus_sel, 4'h3);
      chk("t3_wait_mem_ack", mem_ack, 0);
    end
    step(); #2;
    chk("t3_c5_mem_ack", mem_ack, 1);
    chk("t3_c5_mem_rdata", mem_rdata, 32'hA5A55A5A);
    step(); mem_req = 0;

    // 4: fetch withdrawn mid-transaction
    waits = 1;
    step(); if_req = 1; if_addr = 32'h500;
    step(); if_req = 0; #2;
    chk("t4_c1_cyc", bus_cyc, 1);
    step(); #2;
    chk("t4_c2_cyc", bus_cyc, 1);
    step(); #2;
    chk("t4_c3_if_ack", if_ack, 0);
    chk("t4_c3_cyc", bus_cyc, 0);
    step(); mem_req = 1; mem_we = 0; mem_addr = 32'h600; mem_sel = 4'hF;
    step(); #2;
    chk("t4_c5_cyc", bus_cyc, 1);
    chk("t4_c5_addr", bus_addr, 32'h600);
    step();
    step(); #2;
    chk("t4_c7_mem_ack", mem_ack, 1);
    step(); mem_req = 0;

`ifdef BUS_TIMEOUT_EN
    // 5: slave never answers
    slave_mode = 0; bus_ack = 0;
    step(); if_req = 1; if_addr = 32'h800;
    for (int c = 1; c <= TO_CYC; c++) begin
      step(); #2;
      chk("t5_wait_cyc", bus_cyc, 1);
      chk("t5_wait_err", bus_err, 0);
    end
    step(); #2;
    chk("t5_to_cyc", bus_cyc, 0);
    chk("t5_to_if_ack", if_ack, 1);
    chk("t5_to_err", bus_err, 1);
    chk("t5_to_rdata", if_rdata, 0);
    step(); if_req = 0; #2;
    chk("t5_after_err", bus_err, 0);
`endif

    // 6: reset in the second bus_cyc cycle, then stray acks
    slave_mode = 0; bus_ack = 0;
    step(); mem_req = 1; mem_we = 0; mem_addr = 32'h700; mem_sel = 4'hF;
    step(); #2;
    chk("t6_c1_cyc", bus_cyc, 1);
    step(); rst = 1; #2;
    chk("t6_c2_cyc", bus_cyc, 1);
    step(); rst = 0; mem_req = 0; bus_ack = 1; bus_rdata = 32'h11111111; #2;
    chk("t6_c3_cyc", bus_cyc, 0);
    chk("t6_c3_mem_rdata", mem_rdata, 0);
    step(); #2;
    chk("t6_c4_cyc", bus_cyc, 0);
    chk("t6_c4_mem_ack", mem_ack, 0);
    step(); bus_ack = 0; #2;
    chk("t6_c5_mem_rdata", mem_rdata, 0);
    chk("t6_c5_mem_ack", mem_ack, 0);

    // 7: randomized traffic against the model
    slave_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if (if_got) begin
        if_req = 0; if_got = 0; if_cool = $urandom_range(0, 3);
      end else if (if_req) begin
        if (if_ack) if_got = 1;
        else if ($urandom_range(0, 40) == 0) begin if_req = 0; if_cool = 3; end
      end else if (if_cool > 0) begin
        if_cool--;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (mem_got) begin
        mem_req = 0; mem_got = 0; mem_cool = $urandom_range(0, 4);
      end else if (mem_req) begin
        if (mem_ack) mem_got = 1;
      end else if (mem_cool > 0) begin
        mem_cool--;
      end else if ($urandom_range(0, 3) == 0) begin
        mem_req = 1; mem_we = $urandom_range(0, 1); mem_addr = $urandom;
        mem_wdata = $urandom; mem_sel = 4'($urandom_range(1, 15));
      end
    end
    step(); rst = 0; if_req = 0; mem_req = 0;
    for (int i = 0; i < 20; i++) step();
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
